// File: rtl/card_dealer.sv
// card_dealer: deals a two-player hold'em hand from a 52-card deck without repeats.
// Optional build macro: DEALER_BURN_EN burns one card before each flop/turn/river batch.
module card_dealer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_hand,
    input  logic        next_street,
    output logic        ready,
    output logic [2:0]  stage,
    output logic [41:0] p1_cards,
    output logic [41:0] p2_cards
);
    typedef enum logic [1:0] {IDLE, DRAW, PROBE} state_t;
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
`ifdef DEALER_BURN_EN
    localparam logic BURN = 1'b1;
`else
    localparam logic BURN = 1'b0;
`endif
    localparam logic [2:0] FLOP_N   = BURN ? 3'd4 : 3'd3;
    localparam logic [2:0] STREET_N = BURN ? 3'd2 : 3'd1;
    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [51:0] used_q, used_d;
    logic [41:0] p1_q, p1_d, p2_q, p2_d;
    logic [5:0]  idx_q, idx_d;
    logic [3:0]  pos_q, pos_d;
    logic [2:0]  rem_q, rem_d, stage_q, stage_d;
    logic        burn_q, burn_d, ready_q, ready_d;
    logic [5:0]  cand, pidx, cidx, card;
    logic [3:0]  base;
    logic [1:0]  suit;
    logic [2:0]  slot;
    logic        hit;
    // Galois LFSR advances every cycle regardless of state
    always_comb lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    // Candidate selection, index-to-card mapping, next-state and slot writes
    always_comb begin
        cand    = (lfsr_q[5:0] >= 6'd52) ? lfsr_q[5:0] - 6'd52 : lfsr_q[5:0];
        pidx    = (idx_q == 6'd51) ? 6'd0 : idx_q + 6'd1;
        cidx    = (state_q == DRAW) ? cand : pidx;
        hit     = (state_q != IDLE) && !used_q[cidx];
        suit    = (cidx >= 6'd39) ? 2'd3 : (cidx >= 6'd26) ? 2'd2 : (cidx >= 6'd13) ? 2'd1 : 2'd0;
        base    = (suit == 2'd3) ? 4'd7 : (suit == 2'd2) ? 4'd10 : (suit == 2'd1) ? 4'd13 : 4'd0;
        card    = {suit, cidx[3:0] - base + 4'd2};
        slot    = (pos_q < 4'd4) ? {2'b00, pos_q[1]} : 3'(pos_q - 4'd2);
        state_d = state_q;
        used_d  = used_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        rem_d   = rem_q;
        stage_d = stage_q;
        burn_d  = burn_q;
        if (start_hand) begin
            state_d = DRAW;
            used_d  = '0;
            p1_d    = '0;
            p2_d    = '0;
            pos_d   = '0;
            rem_d   = 3'd4;
            stage_d = 3'd0;
            burn_d  = 1'b0;
        end else if (state_q == IDLE) begin
            if (next_street && stage_q >= 3'd1 && stage_q <= 3'd3) begin
                state_d = DRAW;
                rem_d   = (stage_q == 3'd1) ? FLOP_N : STREET_N;
                burn_d  = BURN;
            end
        end else if (hit) begin
            used_d[cidx] = 1'b1;
            burn_d       = 1'b0;
            rem_d        = rem_q - 3'd1;
            if (!burn_q) begin
                if (pos_q >= 4'd4 || !pos_q[0]) p1_d[6*int'(slot) +: 6] = card;
                if (pos_q >= 4'd4 || pos_q[0]) p2_d[6*int'(slot) +: 6] = card;
                pos_d = pos_q + 4'd1;
            end
            state_d = (rem_q == 3'd1) ? IDLE : DRAW;
            stage_d = (rem_q == 3'd1) ? stage_q + 3'd1 : stage_q;
        end else begin
            idx_d   = cidx;
            state_d = PROBE;
        end
        ready_d = (state_d == IDLE);
    end
    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            used_q  <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            idx_q   <= '0;
            pos_q   <= '0;
            rem_q   <= '0;
            stage_q <= '0;
            burn_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            used_q  <= used_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            stage_q <= stage_d;
            burn_q  <= burn_d;
            ready_q <= ready_d;
        end
    end
    assign ready    = ready_q;
    assign stage    = stage_q;
    assign p1_cards = p1_q;
    assign p2_cards = p2_q;
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed and stress checks for card_dealer.
module tb_card_dealer;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_hand = 1'b0;
    logic        next_street = 1'b0;
    logic        ready;
    logic [2:0]  stage;
    logic [41:0] p1_cards, p2_cards;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_lfsr;
    logic [63:0] seen = '0;
`ifdef DEALER_BURN_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif

    card_dealer dut (
        .clk(clk), .resetn(resetn), .start_hand(start_hand), .next_street(next_street),
        .ready(ready), .stage(stage), .p1_cards(p1_cards), .p2_cards(p2_cards)
    );

    always #5 clk = ~clk;

    // Reference LFSR tracking the design's free-running generator
    always @(posedge clk) m_lfsr <= !resetn ? 16'hACE1 : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));

    function automatic logic [5:0] code_of(int i);
        logic [1:0] s = 2'(i / 13);
        logic [3:0] r = 4'(i % 13 + 2);
        return {s, r};
    endfunction

    function automatic logic valid(logic [5:0] c);
        return c[3:0] >= 4'd2 && c[3:0] <= 4'd14;
    endfunction

    function automatic logic [5:0] slot_of(logic [41:0] b, int k);
        return b[6*k +: 6];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic deal(input bit is_start, input int ncards, input string nm);
        int cyc = 0;
        if (is_start) start_hand = 1'b1; else next_street = 1'b1;
        tick;
        start_hand = 1'b0;
        next_street = 1'b0;
        while (!ready && cyc < 200) begin
            tick;
            cyc++;
        end
        n_cmp++;
        if (!ready || cyc > 10 * ncards) begin
            n_bad++;
            $display("FAIL %s latency: ready=%0b cycles=%0d required ready=1 within %0d", nm, ready, cyc, 10 * ncards);
        end
    endtask

    task automatic check_stage(input logic [2:0] exp, input string nm);
        n_cmp++;
        if (stage !== exp) begin
            n_bad++;
            $display("FAIL %s stage: got %0d required %0d", nm, stage, exp);
        end
    endtask

    task automatic check_hand(input int nvis, input string nm);
        logic [5:0] c[9];
        int n = 0;
        bit bad_valid = 0, bad_zero = 0, bad_eq = 0, bad_dup = 0;
        for (int k = 0; k < 7; k++) begin
            logic [5:0] a = slot_of(p1_cards, k);
            logic [5:0] b = slot_of(p2_cards, k);
            if (k < 2 || k + 2 < nvis) begin
                if (!valid(a) || !valid(b)) bad_valid = 1;
                c[n] = a;
                n++;
                if (k < 2) begin
                    c[n] = b;
                    n++;
                end
            end else if (a !== 6'd0 || b !== 6'd0) bad_zero = 1;
            if (k >= 2 && a !== b) bad_eq = 1;
        end
        for (int i = 0; i < n; i++) begin
            seen[c[i]] = 1'b1;
            for (int j = i + 1; j < n; j++) if (c[i] === c[j]) bad_dup = 1;
        end
        n_cmp += 3;
        if (bad_valid || bad_dup) begin
            n_bad++;
            $display("FAIL %s cards: p1=%h p2=%h required %0d valid distinct cards", nm, p1_cards, p2_cards, nvis);
        end
        if (bad_zero) begin
            n_bad++;
            $display("FAIL %s empty slots: p1=%h p2=%h required undealt slots = 0", nm, p1_cards, p2_cards);
        end
        if (bad_eq) begin
            n_bad++;
            $display("FAIL %s board: p1=%h p2=%h required equal board slots", nm, p1_cards, p2_cards);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        tick;
        tick;
        n_cmp += 3;
        if (p1_cards !== '0 || p2_cards !== '0) begin
            n_bad++;
            $display("FAIL reset buses: p1=%h p2=%h required 0", p1_cards, p2_cards);
        end
        if (stage !== 3'd0) begin
            n_bad++;
            $display("FAIL reset stage: got %0d required 0", stage);
        end
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset ready: got %b required 1", ready);
        end
        resetn = 1'b1;
        tick;
    endtask

    task automatic test_next_ignored_empty;
        next_street = 1'b1;
        tick;
        next_street = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || stage !== 3'd0 || p1_cards !== '0) begin
            n_bad++;
            $display("FAIL next_at_empty: ready=%b stage=%0d p1=%h required ready=1 stage=0 p1=0", ready, stage, p1_cards);
        end
    endtask

    task automatic test_start_hand;
        logic [5:0] raw, cand, exp;
        int cyc = 0;
        start_hand = 1'b1;
        tick;
        start_hand = 1'b0;
        raw = m_lfsr[5:0];
        cand = (raw >= 6'd52) ? raw - 6'd52 : raw;
        exp = code_of(int'(cand));
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL start ready_drop: got %b required 0", ready);
        end
        tick;
        n_cmp++;
        if (slot_of(p1_cards, 0) !== exp) begin
            n_bad++;
            $display("FAIL first_card: got %h required %h", slot_of(p1_cards, 0), exp);
        end
        while (!ready && cyc < 200) begin
            tick;
            cyc++;
        end
        check_stage(3'd1, "start_hand");
        check_hand(4, "start_hand");
    endtask

    task automatic test_same_cycle;
        int cyc = 0;
        start_hand = 1'b1;
        next_street = 1'b1;
        tick;
        start_hand = 1'b0;
        next_street = 1'b0;
        while (!ready && cyc < 200) begin
            tick;
            cyc++;
        end
        check_stage(3'd1, "start_wins");
        check_hand(4, "start_wins");
    endtask

    task automatic test_full_hand;
        logic [41:0] s1, s2;
        deal(1, 4, "full_pre");
        check_stage(3'd1, "full_pre");
        deal(0, 3 + B, "full_flop");
        check_stage(3'd2, "full_flop");
        check_hand(7, "full_flop");
        deal(0, 1 + B, "full_turn");
        check_stage(3'd3, "full_turn");
        check_hand(8, "full_turn");
        deal(0, 1 + B, "full_river");
        check_stage(3'd4, "full_river");
        check_hand(9, "full_river");
        n_cmp++;
        if ($countones(dut.used_q) !== 9 + 3 * B) begin
            n_bad++;
            $display("FAIL used_count: got %0d required %0d", $countones(dut.used_q), 9 + 3 * B);
        end
        s1 = p1_cards;
        s2 = p2_cards;
        next_street = 1'b1;
        tick;
        next_street = 1'b0;
        tick;
        tick;
        check_stage(3'd4, "extra_next");
        n_cmp++;
        if (ready !== 1'b1 || p1_cards !== s1 || p2_cards !== s2) begin
            n_bad++;
            $display("FAIL extra_next buses: ready=%b p1=%h p2=%h required ready=1 p1=%h p2=%h", ready, p1_cards, p2_cards, s1, s2);
        end
    endtask

    task automatic test_abort;
        int cyc = 0;
        deal(1, 4, "abort_pre");
        next_street = 1'b1;
        tick;
        next_street = 1'b0;
        tick;
        start_hand = 1'b1;
        tick;
        start_hand = 1'b0;
        check_stage(3'd0, "abort");
        n_cmp++;
        if (p1_cards !== '0 || p2_cards !== '0 || ready !== 1'b0) begin
            n_bad++;
            $display("FAIL abort clear: p1=%h p2=%h ready=%b required 0/0/0", p1_cards, p2_cards, ready);
        end
        while (!ready && cyc < 200) begin
            tick;
            cyc++;
        end
        check_stage(3'd1, "abort_redeal");
        check_hand(4, "abort_redeal");
    endtask

    task automatic test_stress;
        seen = '0;
        for (int h = 0; h < 800; h++) begin
            deal(1, 4, "stress_pre");
            deal(0, 3 + B, "stress_flop");
            deal(0, 1 + B, "stress_turn");
            deal(0, 1 + B, "stress_river");
            check_hand(9, "stress");
        end
        n_cmp++;
        if ($countones(seen) !== 52) begin
            n_bad++;
            $display("FAIL coverage: distinct codes seen %0d required 52", $countones(seen));
        end
    endtask

    initial begin
        test_reset;
        test_next_ignored_empty;
        test_start_hand;
        test_same_cycle;
        test_full_hand;
        test_abort;
        test_stress;
        test_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
